// File: rtl/nv_ram_fifo_ctrl_64x14.sv
// FIFO controller for an external 64x14 two-port RAM with registered read address and output.
// A two-stage read pipeline (address, output) hides the 2-cycle RAM read latency and stalls losslessly.
module nv_ram_fifo_ctrl_64x14 #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW:0]      count,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [31:0]      ram_pwrbus_ram_pd
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] iss_ptr_q, iss_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        s1_vld_q, s1_vld_d;
  logic        s2_vld_q, s2_vld_d;
  logic        push, pop, adv1, adv2;
  logic [AW:0] avail;

  always_comb begin
    wr_prdy = (count_q < DEPTH_C);
    push    = wr_pvld & wr_prdy;
    rd_pvld = s2_vld_q;
    pop     = s2_vld_q & rd_prdy;
    // Entries written but not yet issued; pointer MSB disambiguates full vs empty.
    avail   = wr_ptr_q - iss_ptr_q;
    adv2    = s1_vld_q & (~s2_vld_q | rd_prdy);
    adv1    = (avail != '0) & (~s1_vld_q | adv2);

    wr_ptr_d  = push ? wr_ptr_q + ONE_C : wr_ptr_q;
    iss_ptr_d = adv1 ? iss_ptr_q + ONE_C : iss_ptr_q;
    s1_vld_d  = adv1 | (s1_vld_q & ~adv2);
    s2_vld_d  = adv2 | (s2_vld_q & ~rd_prdy);

    // Count spans RAM, stage 1 and stage 2, so a slot is never rewritten before its pop.
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !push) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
      count_q   <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      iss_ptr_q <= iss_ptr_d;
      count_q   <= count_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
    end
  end

  assign ram_we            = push;
  assign ram_wa            = wr_ptr_q[AW-1:0];
  assign ram_di            = wr_pd;
  assign ram_re            = adv1;
  assign ram_ra            = iss_ptr_q[AW-1:0];
  assign ram_ore           = adv2;
  assign rd_pd             = ram_dout;
  assign count             = count_q;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == DEPTH_C)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && !s2_vld_q));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);

endmodule
